// File: rtl/gpio_in_filter_if.sv
// Word-addressed register bus shared with the GPIO DDR/open-drain register stage.
interface gpio_in_filter_if #(
  parameter int AddrWidth = 16,
  parameter int BusWidth  = 32
);
  logic                 write_reg;
  logic                 read_reg;
  logic [AddrWidth-3:0] busaddress;
  logic [BusWidth-1:0]  busdata_in;
  logic [BusWidth-1:0]  busdata_out;

  modport master (
    output write_reg, read_reg, busaddress, busdata_in,
    input  busdata_out
  );

  modport slave (
    input  write_reg, read_reg, busaddress, busdata_in,
    output busdata_out
  );
endinterface

// File: rtl/gpio_in_filter.sv
// GPIO input path: two-flop synchronizer, per-bit programmable glitch filter,
// sticky edge flags with W1C clear, level interrupt and register read-back.
module gpio_in_filter #(
  parameter int AddrWidth      = 16,
  parameter int BusWidth       = 32,
  parameter int MuxGPIOIOWidth = 34,
  parameter int FilterWidth    = 8
) (
  input  logic                      reg_clk,
  input  logic                      reset_reg_N,
  input  logic [MuxGPIOIOWidth-1:0] iodatatohm3,
  gpio_in_filter_if.slave           bus,
  output logic [MuxGPIOIOWidth-1:0] filtered_io,
  output logic                      irq
);
  localparam int HiWidth = MuxGPIOIOWidth - 32;

  localparam logic [AddrWidth-1:0] AddrFiltTc  = AddrWidth'(32'h1400);
  localparam logic [AddrWidth-1:0] AddrInLo    = AddrWidth'(32'h1404);
  localparam logic [AddrWidth-1:0] AddrInHi    = AddrWidth'(32'h1408);
  localparam logic [AddrWidth-1:0] AddrEdgeLo  = AddrWidth'(32'h140C);
  localparam logic [AddrWidth-1:0] AddrEdgeHi  = AddrWidth'(32'h1410);
  localparam logic [AddrWidth-1:0] AddrIrqenLo = AddrWidth'(32'h1414);
  localparam logic [AddrWidth-1:0] AddrIrqenHi = AddrWidth'(32'h1418);

  logic [MuxGPIOIOWidth-1:0] sync_1;
  logic [MuxGPIOIOWidth-1:0] sync_2;
  logic [MuxGPIOIOWidth-1:0] filt_d;
  logic [MuxGPIOIOWidth-1:0] edge_flag;
  logic [MuxGPIOIOWidth-1:0] edge_clr;
  logic [MuxGPIOIOWidth-1:0] irqen;
  logic [31:0]               irqen_lo;
  logic [HiWidth-1:0]        irqen_hi;
  logic [FilterWidth-1:0]    filt_tc;
  logic [FilterWidth-1:0]    cnt [MuxGPIOIOWidth];
  logic [AddrWidth-1:0]      byte_addr;
  logic [BusWidth-1:0]       rd_data;
  logic                      wr_edge_lo;
  logic                      wr_edge_hi;

  assign byte_addr  = {bus.busaddress, 2'b00};
  assign wr_edge_lo = bus.write_reg && (byte_addr == AddrEdgeLo);
  assign wr_edge_hi = bus.write_reg && (byte_addr == AddrEdgeHi);
  assign edge_clr   = {(wr_edge_hi ? bus.busdata_in[HiWidth-1:0] : {HiWidth{1'b0}}),
                       (wr_edge_lo ? bus.busdata_in[31:0] : 32'h0)};
  assign irqen      = {irqen_hi, irqen_lo};

  // The >= compare lets a lowered TC release a running count at once.
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      sync_1      <= '0;
      sync_2      <= '0;
      filtered_io <= '0;
      for (int i = 0; i < MuxGPIOIOWidth; i++) cnt[i] <= '0;
    end else begin
      sync_1 <= iodatatohm3;
      sync_2 <= sync_1;
      for (int i = 0; i < MuxGPIOIOWidth; i++) begin
        if (sync_2[i] == filtered_io[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= filt_tc) begin
          filtered_io[i] <= sync_2[i];
          cnt[i]         <= '0;
        end else begin
          cnt[i] <= cnt[i] + FilterWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      filt_tc  <= '0;
      irqen_lo <= '0;
      irqen_hi <= '0;
    end else if (bus.write_reg) begin
      if (byte_addr == AddrFiltTc)  filt_tc  <= bus.busdata_in[FilterWidth-1:0];
      if (byte_addr == AddrIrqenLo) irqen_lo <= bus.busdata_in[31:0];
      if (byte_addr == AddrIrqenHi) irqen_hi <= bus.busdata_in[HiWidth-1:0];
    end
  end

  // A new edge in the same cycle as its W1C clear keeps the flag set.
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      filt_d    <= '0;
      edge_flag <= '0;
      irq       <= 1'b0;
    end else begin
      filt_d    <= filtered_io;
      edge_flag <= (edge_flag & ~edge_clr) | (filtered_io ^ filt_d);
      irq       <= |(edge_flag & irqen);
    end
  end

  always_comb begin
    rd_data = '0;
    case (byte_addr)
      AddrFiltTc:  rd_data = BusWidth'(filt_tc);
      AddrInLo:    rd_data = BusWidth'(filtered_io[31:0]);
      AddrInHi:    rd_data = BusWidth'(filtered_io[MuxGPIOIOWidth-1:32]);
      AddrEdgeLo:  rd_data = BusWidth'(edge_flag[31:0]);
      AddrEdgeHi:  rd_data = BusWidth'(edge_flag[MuxGPIOIOWidth-1:32]);
      AddrIrqenLo: rd_data = BusWidth'(irqen_lo);
      AddrIrqenHi: rd_data = BusWidth'(irqen_hi);
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      bus.busdata_out <= '0;
    end else if (bus.read_reg) begin
      bus.busdata_out <= rd_data;
    end
  end
endmodule

// File: tb/tb_gpio_in_filter.sv
// Self-checking bench for gpio_in_filter: directed scenarios plus a randomized
// run compared against a sample-window reference model.
module tb_gpio_in_filter;
  localparam int N  = 34;
  localparam int AW = 16;
  localparam int BW = 32;
  localparam int FW = 8;

  logic          reg_clk = 1'b0;
  logic          reset_reg_N = 1'b0;
  logic [N-1:0]  iodatatohm3 = '0;
  logic [N-1:0]  filtered_io;
  logic          irq;
  int            n_checks = 0;
  int            n_fail = 0;

  gpio_in_filter_if #(.AddrWidth(AW), .BusWidth(BW)) bus_if ();

  gpio_in_filter #(
    .AddrWidth(AW), .BusWidth(BW), .MuxGPIOIOWidth(N), .FilterWidth(FW)
  ) dut (
    .reg_clk     (reg_clk),
    .reset_reg_N (reset_reg_N),
    .iodatatohm3 (iodatatohm3),
    .bus         (bus_if),
    .filtered_io (filtered_io),
    .irq         (irq)
  );

  always #5 reg_clk = ~reg_clk;

  // Reference model: a bit flips once its last TC+1 synchronized samples all
  // disagree with the current filtered level.
  logic [N-1:0]  m_filt, m_chg, m_edge, m_irqen;
  logic [FW-1:0] m_tc;
  logic          m_irq;
  logic [BW-1:0] m_rdata;
  logic [N-1:0]  phist [$];

  task automatic model_reset();
    m_filt = '0; m_chg = '0; m_edge = '0; m_irqen = '0;
    m_tc = '0; m_irq = 1'b0; m_rdata = '0;
    phist.delete();
  endtask

  function automatic logic [N-1:0] hist_at(int j);
    return (j < phist.size()) ? phist[j] : '0;
  endfunction

  function automatic logic [BW-1:0] m_read(logic [AW-1:0] a);
    case (a)
      16'h1400: return BW'(m_tc);
      16'h1404: return m_filt[31:0];
      16'h1408: return BW'(m_filt[N-1:32]);
      16'h140C: return m_edge[31:0];
      16'h1410: return BW'(m_edge[N-1:32]);
      16'h1414: return m_irqen[31:0];
      16'h1418: return BW'(m_irqen[N-1:32]);
      default:  return '0;
    endcase
  endfunction

  task automatic model_step();
    logic [N-1:0]  flip;
    logic [N-1:0]  clr;
    logic [AW-1:0] a;
    if (!reset_reg_N) begin
      model_reset();
      return;
    end
    a = {bus_if.busaddress, 2'b00};
    flip = '1;
    for (int j = 1; j <= int'(m_tc) + 1; j++) flip &= hist_at(j) ^ m_filt;
    clr = '0;
    if (bus_if.write_reg && a == 16'h140C) clr[31:0] = bus_if.busdata_in;
    if (bus_if.write_reg && a == 16'h1410) clr[N-1:32] = bus_if.busdata_in[N-33:0];
    if (bus_if.read_reg) m_rdata = m_read(a);
    m_irq  = |(m_edge & m_irqen);
    m_edge = (m_edge & ~clr) | m_chg;
    m_chg  = flip;
    m_filt = m_filt ^ flip;
    if (bus_if.write_reg && a == 16'h1400) m_tc = bus_if.busdata_in[FW-1:0];
    if (bus_if.write_reg && a == 16'h1414) m_irqen[31:0] = bus_if.busdata_in;
    if (bus_if.write_reg && a == 16'h1418) m_irqen[N-1:32] = bus_if.busdata_in[N-33:0];
    phist.push_front(iodatatohm3);
    if (phist.size() > 300) void'(phist.pop_back());
  endtask

  task automatic tick();
    @(posedge reg_clk);
    model_step();
    #1;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [BW-1:0] d);
    bus_if.write_reg = 1'b1;
    bus_if.busaddress = a[AW-1:2];
    bus_if.busdata_in = d;
    tick();
    bus_if.write_reg = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [BW-1:0] d);
    bus_if.read_reg = 1'b1;
    bus_if.busaddress = a[AW-1:2];
    tick();
    bus_if.read_reg = 1'b0;
    d = bus_if.busdata_out;
  endtask

  task automatic test_reset();
    reset_reg_N = 1'b0;
    model_reset();
    repeat (3) tick();
    #2 reset_reg_N = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (filtered_io !== '0) begin n_fail++; $display("FAIL reset_filtered: got %h expected 0", filtered_io); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++;
    if (bus_if.busdata_out !== '0) begin n_fail++; $display("FAIL reset_busdata: got %h expected 0", bus_if.busdata_out); end
  endtask

  task automatic test_filt_tc();
    logic [BW-1:0] d;
    bus_write(16'h1400, 32'h3);
    bus_read(16'h1400, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL filt_tc_readback: got %h expected 3", d); end
  endtask

  task automatic test_bit0_irq();
    logic [BW-1:0] d;
    int n, m;
    bus_write(16'h1414, 32'h1);
    iodatatohm3[0] = 1'b1;
    n = 0;
    while (filtered_io[0] !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++;
    if (n != 6) begin n_fail++; $display("FAIL bit0_rise_latency: got %0d expected 6", n); end
    m = 0;
    while (irq !== 1'b1 && m < 10) begin tick(); m++; end
    n_checks++;
    if (m != 2) begin n_fail++; $display("FAIL bit0_irq_latency: got %0d expected 2", m); end
    bus_read(16'h140C, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL bit0_edge_lo: got %h expected 1", d); end
  endtask

  task automatic test_glitch();
    logic [BW-1:0] d;
    logic seen, rise, fall;
    iodatatohm3[5] = 1'b1;
    repeat (3) tick();
    iodatatohm3[5] = 1'b0;
    seen = 1'b0;
    repeat (12) begin tick(); if (filtered_io[5]) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL glitch3_filtered: got %b expected 0", seen); end
    bus_read(16'h140C, d);
    n_checks++;
    if (d[5] !== 1'b0) begin n_fail++; $display("FAIL glitch3_edge: got %b expected 0", d[5]); end
    iodatatohm3[5] = 1'b1;
    repeat (4) tick();
    iodatatohm3[5] = 1'b0;
    rise = 1'b0; fall = 1'b0;
    repeat (16) begin
      tick();
      if (filtered_io[5]) rise = 1'b1;
      else if (rise) fall = 1'b1;
    end
    n_checks++;
    if ({rise, fall} !== 2'b11) begin n_fail++; $display("FAIL pulse4_rise_fall: got %b expected 11", {rise, fall}); end
    bus_read(16'h140C, d);
    n_checks++;
    if (d !== 32'h21) begin n_fail++; $display("FAIL pulse4_edge_lo: got %h expected 21", d); end
  endtask

  task automatic test_w1c_collision();
    logic [BW-1:0] d;
    int n;
    iodatatohm3[0] = 1'b0;
    n = 0;
    while (filtered_io[0] !== 1'b0 && n < 20) begin tick(); n++; end
    n_checks++;
    if (n != 6) begin n_fail++; $display("FAIL bit0_fall_latency: got %0d expected 6", n); end
    bus_write(16'h140C, 32'h1);
    bus_read(16'h140C, d);
    n_checks++;
    if (d !== 32'h21) begin n_fail++; $display("FAIL w1c_set_wins: got %h expected 21", d); end
    bus_write(16'h140C, 32'h1);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_hold: got %b expected 1", irq); end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_fall: got %b expected 0", irq); end
    bus_read(16'h140C, d);
    n_checks++;
    if (d !== 32'h20) begin n_fail++; $display("FAIL w1c_clear: got %h expected 20", d); end
  endtask

  task automatic test_bit33();
    logic [BW-1:0] d;
    int n;
    bus_write(16'h1400, 32'h0);
    iodatatohm3[33] = 1'b1;
    n = 0;
    while (filtered_io[33] !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++;
    if (n != 3) begin n_fail++; $display("FAIL bit33_latency: got %0d expected 3", n); end
    bus_read(16'h1408, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL bit33_in_hi: got %h expected 2", d); end
    bus_read(16'h1410, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL bit33_edge_hi: got %h expected 2", d); end
    iodatatohm3[33] = 1'b0;
    bus_read(16'h1420, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", d); end
    repeat (3) tick();
    n_checks++;
    if (filtered_io[33] !== 1'b0) begin n_fail++; $display("FAIL bit33_fall: got %b expected 0", filtered_io[33]); end
  endtask

  task automatic test_reset_mid_count();
    logic [BW-1:0] d;
    int n;
    iodatatohm3[7] = 1'b1;
    repeat (4) tick();
    bus_write(16'h1418, 32'h2);
    bus_write(16'h1400, 32'd200);
    iodatatohm3[9] = 1'b1;
    repeat (40) tick();
    n_checks++;
    if (filtered_io[9] !== 1'b0) begin n_fail++; $display("FAIL tc200_still_counting: got %b expected 0", filtered_io[9]); end
    bus_read(16'h1400, d);
    n_checks++;
    if (d !== 32'd200) begin n_fail++; $display("FAIL tc200_readback: got %h expected c8", d); end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
    #3 reset_reg_N = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (filtered_io !== '0) begin n_fail++; $display("FAIL async_reset_filtered: got %h expected 0", filtered_io); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL async_reset_irq: got %b expected 0", irq); end
    n_checks++;
    if (bus_if.busdata_out !== '0) begin n_fail++; $display("FAIL async_reset_busdata: got %h expected 0", bus_if.busdata_out); end
    #2 reset_reg_N = 1'b1;
    n = 0;
    while (filtered_io[9] !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++;
    if (n != 3) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 3", n); end
    bus_read(16'h1400, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL post_reset_tc: got %h expected 0", d); end
    bus_read(16'h1410, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL post_reset_edge_hi: got %h expected 0", d); end
    bus_read(16'h140C, d);
    n_checks++;
    if (d !== 32'h280) begin n_fail++; $display("FAIL post_reset_edge_lo: got %h expected 280", d); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int op;
    for (int seg = 0; seg < 3; seg++) begin
      bus_write(16'h1400, BW'($urandom_range(0, 4)));
      repeat (250) begin
        op = $urandom_range(0, 15);
        if (op == 0) iodatatohm3 = iodatatohm3 ^ N'({$urandom(), $urandom()});
        else if (op < 4) iodatatohm3[$urandom_range(0, N - 1)] = ~iodatatohm3[$urandom_range(0, N - 1)];
        op = $urandom_range(0, 11);
        bus_if.busdata_in = $urandom();
        if (op == 0) begin bus_if.write_reg = 1'b1; bus_if.busaddress = 14'h503; end
        else if (op == 1) begin bus_if.write_reg = 1'b1; bus_if.busaddress = 14'h504; end
        else if (op == 2) begin bus_if.write_reg = 1'b1; bus_if.busaddress = 14'h505; end
        else if (op == 3) begin bus_if.write_reg = 1'b1; bus_if.busaddress = 14'h506; end
        if (op >= 2 && op < 7) begin
          a = AW'(16'h1400 + 4 * $urandom_range(0, 8));
          bus_if.read_reg = 1'b1;
          if (op >= 4) bus_if.busaddress = a[AW-1:2];
        end
        tick();
        bus_if.write_reg = 1'b0;
        bus_if.read_reg = 1'b0;
        n_checks++;
        if (filtered_io !== m_filt) begin n_fail++; $display("FAIL rand_filtered: got %h expected %h", filtered_io, m_filt); end
        n_checks++;
        if (irq !== m_irq) begin n_fail++; $display("FAIL rand_irq: got %b expected %b", irq, m_irq); end
        n_checks++;
        if (bus_if.busdata_out !== m_rdata) begin n_fail++; $display("FAIL rand_busdata: got %h expected %h", bus_if.busdata_out, m_rdata); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.write_reg = 1'b0;
    bus_if.read_reg = 1'b0;
    bus_if.busaddress = '0;
    bus_if.busdata_in = '0;
    model_reset();
    test_reset();
    test_filt_tc();
    test_bit0_irq();
    test_glitch();
    test_w1c_collision();
    test_bit33();
    test_reset_mid_count();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
